// File: rtl/ibex_ibus_arb_pkg.sv
// ----------------------------------------------------------------------------
// ibex_ibus_arb_pkg
// Shared types and constants for the two-port instruction-bus arbiter.
//   arb_state_e         : IDLE (free to arbitrate) / HOLD (issued, awaiting gnt)
//   owner_t             : requester index carried through the owner FIFO
//   MaxOutstandingLimit : deepest owner FIFO the arbiter supports
//   rr_pick()           : round-robin winner between two requesters
// ----------------------------------------------------------------------------
package ibex_ibus_arb_pkg;

    typedef enum logic {
        ArbIdle,
        ArbHold
    } arb_state_e;

    typedef logic [0:0] owner_t;

    localparam int MaxOutstandingLimit = 4;

    // A lone requester wins outright; on contention the requester that did
    // not receive the previous grant wins.
    function automatic owner_t rr_pick(input logic [1:0] req, input owner_t last);
        if (req == 2'b11) begin
            return ~last;
        end
        return owner_t'(req[1]);
    endfunction

endpackage

// File: rtl/ibex_ibus_arb_owner_fifo.sv
// ----------------------------------------------------------------------------
// ibex_ibus_arb_owner_fifo
// Records which requester owns each granted-but-unanswered bus transaction,
// in grant order, so in-order responses can be routed back.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push         : append push_owner (ignored when full unless popping too)
//   push_owner   : requester index to append
//   pop          : remove the head entry (ignored when empty)
//   head         : oldest outstanding owner
//   full, empty  : occupancy flags
// A push and a pop in the same cycle leave occupancy unchanged, and a push
// into a full FIFO is accepted when the same cycle pops the head.
// ----------------------------------------------------------------------------
module ibex_ibus_arb_owner_fifo
    import ibex_ibus_arb_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push,
    input  owner_t push_owner,
    input  logic   pop,
    output owner_t head,
    output logic   full,
    output logic   empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    owner_t          mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CntW'(Depth));
    assign do_pop  = pop && !empty;
    // The slot being popped is reusable in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_owner;
        end
    end

endmodule

// File: rtl/ibex_ibus_arbiter.sv
// ----------------------------------------------------------------------------
// ibex_ibus_arbiter
// Shares one pipelined, in-order instruction bus between the prefetch buffer
// (port 0) and a secondary fetch master (port 1).
// Parameters:
//   MaxOutstanding : granted-but-unanswered transactions allowed (1..4)
//   ResetPriority  : requester favoured on the first contended cycle
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   lock_i              : (IBEX_IBUS_ARB_LOCK_EN only) keep bus on port 1
//   req_i, addr_i       : per-requester request and word address
//   gnt_o               : per-requester grant (one-hot or zero)
//   rdata_o, rvalid_o,
//   err_o               : per-requester response
//   m_req_o, m_gnt_i,
//   m_addr_o, m_rdata_i,
//   m_rvalid_i, m_err_i : shared bus
//   busy_o              : transactions outstanding or a request on the bus
//   proto_err_o         : sticky, response seen with nothing outstanding
// Optional feature macro: IBEX_IBUS_ARB_LOCK_EN. When defined, lock_i masks
// port 0 while port 1 holds the last grant, giving port 1 atomic bursts.
// ----------------------------------------------------------------------------
module ibex_ibus_arbiter
    import ibex_ibus_arb_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int ResetPriority  = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef IBEX_IBUS_ARB_LOCK_EN
    input  logic             lock_i,
`endif
    input  logic [1:0]       req_i,
    input  logic [1:0][31:0] addr_i,
    output logic [1:0]       gnt_o,
    output logic [1:0][31:0] rdata_o,
    output logic [1:0]       rvalid_o,
    output logic [1:0]       err_o,
    output logic             m_req_o,
    input  logic             m_gnt_i,
    output logic [31:0]      m_addr_o,
    input  logic [31:0]      m_rdata_i,
    input  logic             m_rvalid_i,
    input  logic             m_err_i,
    output logic             busy_o,
    output logic             proto_err_o
);

    localparam int FifoDepth =
        (MaxOutstanding > MaxOutstandingLimit) ? MaxOutstandingLimit :
        (MaxOutstanding < 1)                   ? 1 : MaxOutstanding;

    // The pointer starts at the requester that is NOT favoured, so the
    // favoured one wins the first contended cycle.
    localparam owner_t ResetLast = (ResetPriority == 0) ? 1'b1 : 1'b0;

    arb_state_e  state;
    owner_t      hold_owner;
    logic [31:0] hold_addr;
    owner_t      last_gnt;
    logic        proto_err;

    logic        resp;
    logic        pop;
    logic        push;
    logic        room;
    logic        fifo_full;
    logic        fifo_empty;
    owner_t      head;
    logic [1:0]  req_eff;
    owner_t      winner;
    logic        issue;
    owner_t      issue_owner;
    logic [31:0] issue_addr;

    assign resp = m_rvalid_i | m_err_i;
    assign pop  = resp & ~fifo_empty;
    // A same-cycle response frees a slot, so a full FIFO can still accept.
    assign room = ~fifo_full | pop;

    always_comb begin
        req_eff = req_i;
`ifdef IBEX_IBUS_ARB_LOCK_EN
        if (lock_i && (last_gnt == 1'b1)) begin
            req_eff[0] = 1'b0;
        end
`endif
    end

    assign winner = rr_pick(req_eff, last_gnt);

    // HOLD keeps the stalled owner and its registered address on the bus;
    // IDLE forwards the winner with no added latency.
    always_comb begin
        issue       = 1'b0;
        issue_owner = winner;
        issue_addr  = '0;
        if (state == ArbHold) begin
            issue       = 1'b1;
            issue_owner = hold_owner;
            issue_addr  = hold_addr;
        end else if (room && (req_eff != 2'b00)) begin
            issue      = 1'b1;
            issue_addr = addr_i[winner];
        end
    end

    assign push = issue & m_gnt_i;

    ibex_ibus_arb_owner_fifo #(
        .Depth (FifoDepth)
    ) u_owner_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push),
        .push_owner (issue_owner),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ArbIdle;
            hold_owner <= '0;
            last_gnt   <= ResetLast;
            proto_err  <= 1'b0;
        end else begin
            if (resp && fifo_empty) begin
                proto_err <= 1'b1;
            end
            if (push) begin
                state    <= ArbIdle;
                last_gnt <= issue_owner;
            end else if (issue) begin
                state      <= ArbHold;
                hold_owner <= issue_owner;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state == ArbIdle) && issue && !m_gnt_i) begin
            hold_addr <= issue_addr;
        end
    end

    // Every output is forced low while reset is held, including the purely
    // combinational pass-through paths.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        err_o    = '0;
        if (!rst_i) begin
            if (push) begin
                gnt_o[issue_owner] = 1'b1;
            end
            if (pop) begin
                rvalid_o[head] = m_rvalid_i;
                err_o[head]    = m_err_i;
            end
        end
    end

    assign rdata_o[0]  = rst_i ? '0 : m_rdata_i;
    assign rdata_o[1]  = rst_i ? '0 : m_rdata_i;
    assign m_req_o     = issue & ~rst_i;
    assign m_addr_o    = rst_i ? '0 : issue_addr;
    assign busy_o      = ~rst_i & (~fifo_empty | issue);
    assign proto_err_o = proto_err;

    // A stalled requester must keep its request up until the bus accepts it.
    hold_req_kept: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == ArbHold) |-> req_i[hold_owner]);

endmodule
